// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID/EX stage register: control bundle layout,
// hazard FSM state encoding and the all-zero bubble control word.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_W = 27;

  // Control bundle field offsets (LSB of each field)
  localparam int unsigned OFF_OPFUNCT   = 0;   // [9:0]
  localparam int unsigned OFF_RAM_SIZE  = 10;  // [11:10]
  localparam int unsigned OFF_SHIFT_IMM = 12;  // [14:12]
  localparam int unsigned OFF_ALU_OP    = 15;  // [18:15]
  localparam int unsigned OFF_AUIPC     = 19;
  localparam int unsigned OFF_JAL       = 20;
  localparam int unsigned OFF_JALR      = 21;
  localparam int unsigned OFF_RAM_SE    = 22;
  localparam int unsigned OFF_RAM_RW    = 23;
  localparam int unsigned OFF_RAM_EN    = 24;
  localparam int unsigned OFF_RF_EN     = 25;
  localparam int unsigned OFF_LOAD      = 26;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } fsm_state_t;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_bubble_fsm.sv
// Load-use bubble sequencer: decides per edge whether the stage register
// loads, inserts a bubble or holds, and drives the upstream hold request.
module hazard_bubble_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic load_use,
  output logic insert_bubble,
  output logic load_en,
  output logic upstream_hold
);

  localparam logic [3:0] CNT_INIT = 4'(STALL_LEN - 1);
  localparam fsm_state_t LU_STATE = (STALL_LEN > 1) ? BUBBLE : RUN;

  fsm_state_t r_state;
  fsm_state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    insert_bubble = 1'b0;
    load_en       = 1'b0;
    upstream_hold = stall;
    unique case (r_state)
      RUN: begin
        upstream_hold = stall | (load_use & ~flush);
        if (!stall) begin
          if (flush) begin
            insert_bubble = 1'b1;
          end else if (load_use) begin
            insert_bubble = 1'b1;
            w_cnt_nxt     = CNT_INIT;
            w_state_nxt   = LU_STATE;
          end else begin
            load_en = 1'b1;
          end
        end
      end
      BUBBLE: begin
        upstream_hold = 1'b1;
        // load_use is deliberately ignored while a sequence is running
        if (!stall) begin
          insert_bubble = 1'b1;
          if (flush || r_cnt == 4'd1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_bubble_stage_reg.sv
// ID/EX pipeline register with stall hold, flush squash and automatic
// load-use bubbles. Define PIPE_BUBBLE_STATS_EN to add the bubble_count port.
module pipe_bubble_stage_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W    = pipe_ctrl_pkg::CTRL_W,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_DATA  = 3,
  parameter int unsigned STALL_LEN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       load_use,
  output logic                       out_valid,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic                       upstream_hold
`ifdef PIPE_BUBBLE_STATS_EN
  ,
  output logic [15:0]                bubble_count
`endif
);

  logic                       w_insert_bubble;
  logic                       w_load_en;
  logic                       r_valid;
  logic [CTRL_W-1:0]          r_ctrl;
  logic [NUM_DATA*DATA_W-1:0] r_data;

  hazard_bubble_fsm #(
    .STALL_LEN(STALL_LEN)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .load_use      (load_use),
    .insert_bubble (w_insert_bubble),
    .load_en       (w_load_en),
    .upstream_hold (upstream_hold)
  );

  // Bubbles clear valid and control only; data keeps its last value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (w_insert_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_W'(BUBBLE_CTRL);
    end else if (w_load_en) begin
      r_valid <= in_valid;
      r_ctrl  <= in_ctrl;
      r_data  <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;

`ifdef PIPE_BUBBLE_STATS_EN
  logic [15:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (w_insert_bubble && r_bubble_count != '1) begin
      r_bubble_count <= r_bubble_count + 16'd1;
    end
  end

  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_pipe_bubble_stage_reg.sv
// Scoreboard bench for pipe_bubble_stage_reg with STALL_LEN=3: an
// independent reference model queues expected outputs per driven cycle.
module tb_pipe_bubble_stage_reg;

  localparam int unsigned CW = 27;
  localparam int unsigned DW = 96;
  localparam int unsigned SL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          flush;
  logic          load_use;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          upstream_hold;
`ifdef PIPE_BUBBLE_STATS_EN
  logic [15:0]   bubble_count;
`endif

  always #5 clk = ~clk;

  pipe_bubble_stage_reg #(
    .CTRL_W   (CW),
    .DATA_W   (32),
    .NUM_DATA (3),
    .STALL_LEN(SL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .stall        (stall),
    .flush        (flush),
    .load_use     (load_use),
    .out_valid    (out_valid),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .upstream_hold(upstream_hold)
`ifdef PIPE_BUBBLE_STATS_EN
    ,
    .bubble_count (bubble_count)
`endif
  );

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: m_rem counts bubbles still owed after the current one
  logic          m_v;
  logic [CW-1:0] m_c;
  logic [DW-1:0] m_d;
  int            m_rem;
  int            m_bub;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; flush = 1'b0; load_use = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq("rst_valid", 128'(out_valid), 128'(0));
      check_eq("rst_ctrl", 128'(out_ctrl), 128'(0));
      check_eq("rst_data", 128'(out_data), 128'(0));
      check_eq("rst_hold", 128'(upstream_hold), 128'(0));
    end
    m_v = 1'b0; m_c = '0; m_d = '0; m_rem = 0; m_bub = 0;
    q.delete();
    rst = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic s, input logic f, input logic lu);
    exp_t e;
    logic exp_hold;
    in_valid = v; in_ctrl = c; in_data = d;
    stall = s; flush = f; load_use = lu;
    #1;
    exp_hold = s | (m_rem > 0) | (m_rem == 0 && lu && !f);
    check_eq("upstream_hold", 128'(upstream_hold), 128'(exp_hold));
    if (!s) begin
      if (f) begin
        m_v = 1'b0; m_c = '0; m_rem = 0; m_bub++;
      end else if (m_rem > 0) begin
        m_v = 1'b0; m_c = '0; m_rem--; m_bub++;
      end else if (lu) begin
        m_v = 1'b0; m_c = '0; m_rem = SL - 1; m_bub++;
      end else begin
        m_v = v; m_c = c; m_d = d;
      end
    end
    e.v = m_v; e.c = m_c; e.d = m_d;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      check_eq("queue_empty", 128'(1), 128'(0));
    end else begin
      e = q.pop_front();
      check_eq("out_valid", 128'(out_valid), 128'(e.v));
      check_eq("out_ctrl", 128'(out_ctrl), 128'(e.c));
      check_eq("out_data", 128'(out_data), 128'(e.d));
    end
  endtask

  logic [DW-1:0] d1;
  logic [DW-1:0] d2;

  initial begin
    d1 = {32'h3333_3333, 32'h2222_2222, 32'h0000_0040};
    d2 = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h0000_0080};

    // 1. reset and normal pass
    do_reset(2);
    cyc(1'b1, 27'h1234567, d1, 1'b0, 1'b0, 1'b0);
    check_eq("t1_ctrl", 128'(out_ctrl), 128'(27'h1234567));
    check_eq("t1_word0", 128'(out_data[31:0]), 128'(32'h40));

    // 2. stall hold
    cyc(1'b1, 27'h5, d2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 27'h7, d1, 1'b1, 1'b0, 1'b0);
    check_eq("t2_ctrl_held", 128'(out_ctrl), 128'(27'h5));
    cyc(1'b1, 27'h7, d1, 1'b0, 1'b0, 1'b0);

    // 3. flush, then flush held across two stall cycles
    cyc(1'b1, 27'h3FF, d2, 1'b0, 1'b1, 1'b0);
    check_eq("t3_data_kept", 128'(out_data), 128'(d1));
    cyc(1'b1, 27'h11, d2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 27'h3FF, d1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 27'h3FF, d1, 1'b1, 1'b1, 1'b0);
    check_eq("t3_stalled_valid", 128'(out_valid), 128'(1));
    cyc(1'b1, 27'h3FF, d1, 1'b0, 1'b1, 1'b0);
    check_eq("t3_flushed_ctrl", 128'(out_ctrl), 128'(0));

    // 4. load-use pulse: three bubbles then the held instruction loads
    cyc(1'b1, 27'h7ABCDEF, d2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 27'h7ABCDEF, d2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 27'h7ABCDEF, d2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 27'h7ABCDEF, d2, 1'b0, 1'b0, 1'b0);
    check_eq("t4_loaded", 128'(out_ctrl), 128'(27'h7ABCDEF));

    // 5a. flush during the second BUBBLE-state cycle
    cyc(1'b1, 27'h55, d1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 27'h55, d1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 27'h55, d1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 27'h66, d2, 1'b0, 1'b0, 1'b0);
    // 5b. flush and load_use together: one bubble, no sequence
    cyc(1'b1, 27'h77, d1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 27'h78, d1, 1'b0, 1'b0, 1'b0);
    // 5c. stall inside a sequence, load_use held over the sequence end
    cyc(1'b1, 27'h79, d2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 27'h79, d2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 27'h79, d2, 1'b0, 1'b0, 1'b1);
    // 5d. reset mid-sequence returns to RUN
    cyc(1'b1, 27'h7A, d1, 1'b0, 1'b0, 1'b1);
    do_reset(1);
    cyc(1'b1, 27'h7B, d1, 1'b0, 1'b0, 1'b0);
    check_eq("t5_after_rst", 128'(out_ctrl), 128'(27'h7B));

    // Random mix
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), CW'($urandom), {$urandom, $urandom, $urandom},
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 4) == 0));
    end

`ifdef PIPE_BUBBLE_STATS_EN
    check_eq("bubble_count", 128'(bubble_count), 128'((m_bub > 65535) ? 65535 : m_bub));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_bubble_stage_reg.md
Name: pipe_bubble_stage_reg

Overview:
- Parametrised ID/EX-style pipeline stage register with hazard handling.
- Carries a control bundle plus NUM_DATA data words and holds them under stall.
- On flush, zeroes the control bundle: the squashed instruction becomes a no-op.
- On a load-use hazard, a small FSM inserts STALL_LEN bubbles automatically and holds upstream (PC, IF/ID) until the sequence is done.

Parameters:
- CTRL_W, 27, width of the control bundle: load, rf_en, ram_en, ram_rw, ram_se, jalr, jal, auipc, alu_op[4], shift_imm[3], ram_size[2], opfunct[10].
- DATA_W, 32, width of each data word.
- NUM_DATA, 3, number of data words carried (PC, rs1 value, rs2 value).
- STALL_LEN, 1, bubbles inserted per load-use event; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction is valid.
- in_ctrl  in  CTRL_W  control bundle from the decoder.
- in_data  in  NUM_DATA*DATA_W  data words; word k occupies bits [k*DATA_W +: DATA_W].
- stall  in  1  downstream hold request; the register freezes.
- flush  in  1  branch/jump kill; squashes the instruction currently entering.
- load_use  in  1  load-use hazard detected on the incoming instruction.
- out_valid  out  1  registered valid.
- out_ctrl  out  CTRL_W  registered control bundle.
- out_data  out  NUM_DATA*DATA_W  registered data words.
- upstream_hold  out  1  combinational; asserted while IF and ID must hold.

Behaviour:
Clock and reset:
- One clock (clk). Reset is synchronous and active-high (rst).
- While rst is sampled high: out_valid=0, out_ctrl=0, out_data=0, state=RUN, cnt=0.
- Reset has top priority and aborts any bubble sequence in progress.

Latency and priority:
- Latency is one cycle.
- Per-edge priority: rst > stall > flush > load_use > normal load.

Bubble definition:
- out_valid<=0 and out_ctrl<=0.
- out_data keeps its previous value, for deterministic waveforms.

State RUN:
- stall=1: all registers hold. stall has priority over flush; the controller must keep flush asserted until stall drops.
- flush=1: bubble. State stays RUN.
- load_use=1: bubble. cnt<=STALL_LEN-1. If STALL_LEN>1, go to BUBBLE; otherwise stay in RUN.
- Otherwise (normal load): out_valid<=in_valid, out_ctrl<=in_ctrl, out_data<=in_data.

State BUBBLE:
- stall=1: hold everything, including cnt.
- flush=1: bubble, cnt<=0, go to RUN.
- Otherwise: bubble. If cnt==1, then cnt<=0 and go to RUN; else cnt<=cnt-1.
- load_use is ignored in BUBBLE.

upstream_hold:
- Equals (state==BUBBLE) | (state==RUN & load_use & ~flush) | stall.
- In RUN with load_use=1, this holds upstream for the cycle in which the first bubble is inserted.

Boundary cases:
- cnt width is 4 bits.
- If load_use is still high in RUN after a sequence ends, a new sequence starts; this is legal.
- flush and load_use together: flush wins, only one bubble is inserted, no FSM entry.
- Unused control fields are zeroed like all others; no field is exempt.

Optional Feature:
- Macro: PIPE_BUBBLE_STATS_EN.
- When defined:
  - Adds output port bubble_count, out, 16 bits.
  - Counts every bubble actually written, from flush or load_use, in RUN or BUBBLE.
  - Saturates at 16'hFFFF, clears on rst, does not count while stall=1.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - CTRL_W localparam and per-field bit offsets.
  - FSM state enum with two states: RUN and BUBBLE.
  - The BUBBLE_CTRL all-zero constant.
- Sub-module hazard_bubble_fsm:
  - Holds state and cnt.
  - Outputs insert_bubble, load_en and upstream_hold.
  - The top level holds only the data and control registers plus the optional counter.

Test Plan:
1. Reset and normal pass: rst for 2 cycles, then in_valid=1, in_ctrl=27'h1234567, word0=32'h00000040 → next cycle out_valid=1, out_ctrl=27'h1234567, word0=32'h40; during reset all outputs are 0.
2. Stall hold: load ctrl=27'h5, then stall=1 for 3 cycles while in_ctrl changes to 27'h7 → out_ctrl stays 27'h5 and upstream_hold=1 for all 3 cycles.
3. Flush: flush=1 with in_valid=1, in_ctrl=27'h3FF → next cycle out_valid=0, out_ctrl=0, out_data unchanged; a flush held through 2 stall cycles takes effect on the first unstalled edge.
4. Load-use, STALL_LEN=3: pulse load_use=1 for one cycle → exactly 3 consecutive bubbles, upstream_hold=1 for 3 cycles, then the normal load of the held in_ctrl.
5. Corner cases: flush in the second BUBBLE cycle (STALL_LEN=3) → one bubble, back to RUN with upstream_hold=0; flush and load_use in the same cycle → single bubble, no FSM entry; rst mid-sequence → RUN, cnt=0.
6. PIPE_BUBBLE_STATS_EN build: 2 flushes, one load_use with STALL_LEN=2, and one stall during a flush → bubble_count=4; force the preload to 16'hFFFE, add 3 bubbles → reads 16'hFFFF.
